// File: rtl/be_pkg.sv
`default_nettype none
// =============================================================================
// be_pkg : shared types and sizes for the boolean-equation truth-table sweeper
// Rev 1.0 : initial release
// =============================================================================
package be_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } be_state_e;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int MISS_W  = 5;
    localparam int DWELL_W = 8;

endpackage : be_pkg
`default_nettype wire

// File: rtl/be_dwell_cnt.sv
`default_nettype none
// =============================================================================
// be_dwell_cnt : per-vector dwell counter, flags the last cycle of each dwell
// Rev 1.0 : initial release
// =============================================================================
module be_dwell_cnt
    import be_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam logic [DWELL_W-1:0] C_LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    assign tc = (cnt_q == C_LAST);

    // Wraps to zero on terminal count so consecutive vectors need no gap cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : be_dwell_cnt
`default_nettype wire

// File: rtl/be_sweep.sv
`default_nettype none
// =============================================================================
// be_sweep : drives all 16 {a,b,c,d} vectors, captures z into a truth table
//            and counts disagreements with a golden table
// Rev 1.0 : initial release
// =============================================================================
module be_sweep
    import be_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_VEC-1:0]   expected,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    output logic                 d,
    input  logic                 z,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_VEC-1:0]   tt,
    output logic [MISS_W-1:0]    mismatch_cnt,
    output logic                 pass,
    output logic [VEC_W-1:0]     vec_idx
);

    localparam logic [VEC_W-1:0] C_LAST_VEC = VEC_W'(NUM_VEC - 1);

    be_state_e            state_q, state_d;
    logic [VEC_W-1:0]     vec_q,   vec_d;
    logic [NUM_VEC-1:0]   tt_q,    tt_d;
    logic [MISS_W-1:0]    miss_q,  miss_d;
    logic                 pass_q,  pass_d;

    logic                 w_accept;
    logic                 w_run;
    logic                 w_tc;
    logic                 w_miss_bit;
    logic [MISS_W-1:0]    w_miss_next;

    assign w_accept    = (state_q == IDLE) && start;
    assign w_run       = (state_q == RUN);
    assign w_miss_bit  = (z != expected[vec_q]);
    assign w_miss_next = miss_q + MISS_W'(w_miss_bit);

    be_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .en    (w_run),
        .tc    (w_tc)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        tt_d    = tt_q;
        miss_d  = miss_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    tt_d    = '0;
                    miss_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (w_tc) begin
                    tt_d[vec_q] = z;
                    miss_d      = w_miss_next;
                    if (vec_q != C_LAST_VEC) begin
                        vec_d = vec_q + VEC_W'(1);
                    end else begin
                        // Final count is only known this edge, so judge pass on it directly.
                        state_d = DONE;
                        pass_d  = (w_miss_next == '0);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            tt_q    <= '0;
            miss_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            tt_q    <= tt_d;
            miss_q  <= miss_d;
            pass_q  <= pass_d;
        end
    end

    assign {a, b, c, d}  = w_run ? vec_q : '0;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign tt            = tt_q;
    assign mismatch_cnt  = miss_q;
    assign pass          = pass_q;
    assign vec_idx       = vec_q;

endmodule : be_sweep
`default_nettype wire

// File: tb/tb_be_sweep.sv
`default_nettype none
// =============================================================================
// tb_be_sweep : directed bench for be_sweep (DWELL=4 and DWELL=1 instances)
// Rev 1.0 : initial release
// =============================================================================
module tb_be_sweep;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, start1;
    logic        zero_z;
    logic [15:0] expected, expected1;
    logic        a, b, c, d, z, busy, done, pass;
    logic        a1, b1, c1, d1, z1, busy1, done1, pass1;
    logic [15:0] tt, tt1;
    logic [4:0]  mcnt, mcnt1;
    logic [3:0]  vidx, vidx1;

    int n_cmp = 0;
    int n_bad = 0;

    // Downstream equation z = (a&b)|(c&~d)
    assign z  = zero_z ? 1'b0 : ((a & b) | (c & ~d));
    assign z1 = (a1 & b1) | (c1 & ~d1);

    be_sweep #(.DWELL(4)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .a(a), .b(b), .c(c), .d(d), .z(z),
        .busy(busy), .done(done), .tt(tt), .mismatch_cnt(mcnt),
        .pass(pass), .vec_idx(vidx)
    );

    be_sweep #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected1),
        .a(a1), .b(b1), .c(c1), .d(d1), .z(z1),
        .busy(busy1), .done(done1), .tt(tt1), .mismatch_cnt(mcnt1),
        .pass(pass1), .vec_idx(vidx1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".abcd"}, {a, b, c, d}, 0);
        chk({tag, ".tt"}, tt, 0);
        chk({tag, ".mcnt"}, mcnt, 0);
        chk({tag, ".pass"}, pass, 0);
        chk({tag, ".vidx"}, vidx, 0);
    endtask

    // Launch a sweep on the DWELL=4 instance; optionally re-pulse start or
    // pulse rst when a given vector is reached. Edges are counted from the
    // edge that accepts start.
    task automatic sweep(input int restart_vec, input int rst_vec,
                         output int done_edge, output int pulses);
        bit restarted = 0;
        bit rsted = 0;
        done_edge = -1;
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept.busy", busy, 1);
        chk("accept.vidx", vidx, 0);
        chk("accept.tt_cleared", tt, 0);
        chk("accept.mcnt_cleared", mcnt, 0);
        chk("accept.pass_cleared", pass, 0);
        for (int n = 1; n <= 90; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                pulses++;
                if (done_edge < 0) done_edge = n;
            end
            if (restart_vec >= 0 && !restarted && busy && vidx == 4'(restart_vec)) begin
                restarted = 1;
                start = 1'b1;
            end
            if (rst_vec >= 0 && !rsted && busy && vidx == 4'(rst_vec)) begin
                rsted = 1;
                chk("pre_rst.abcd", {a, b, c, d}, rst_vec);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk_zero("rst_mid");
            end
        end
    endtask

    int de, np;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        zero_z = 1'b0;
        expected = 16'hF444;
        expected1 = 16'hF444;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Scenario 1: golden matches
        sweep(-1, -1, de, np);
        chk("s1.done_edge", de, 64);
        chk("s1.pulses", np, 1);
        chk("s1.tt", tt, 16'hF444);
        chk("s1.mcnt", mcnt, 0);
        chk("s1.pass", pass, 1);
        chk("s1.busy_after", busy, 0);

        // Scenario 2: one golden bit wrong
        expected = 16'hF445;
        sweep(-1, -1, de, np);
        chk("s2.tt", tt, 16'hF444);
        chk("s2.mcnt", mcnt, 1);
        chk("s2.pass", pass, 0);

        // Scenario 3: z stuck low against all-ones golden
        zero_z = 1'b1;
        expected = 16'hFFFF;
        sweep(-1, -1, de, np);
        chk("s3.tt", tt, 16'h0000);
        chk("s3.mcnt", mcnt, 16);
        chk("s3.pass", pass, 0);
        zero_z = 1'b0;
        expected = 16'hF444;

        // Scenario 4: start re-pulsed mid-sweep is ignored
        sweep(5, -1, de, np);
        chk("s4.done_edge", de, 64);
        chk("s4.pulses", np, 1);
        chk("s4.tt", tt, 16'hF444);
        chk("s4.pass", pass, 1);

        // Scenario 5: reset at vector 7 aborts, then a fresh sweep completes
        sweep(-1, 7, de, np);
        chk("s5.pulses", np, 0);
        chk("s5.tt_after", tt, 0);
        sweep(-1, -1, de, np);
        chk("s5b.done_edge", de, 64);
        chk("s5b.tt", tt, 16'hF444);
        chk("s5b.pass", pass, 1);

        // Scenario 6: DWELL=1 steps one vector per clock
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        chk("d1.abcd0", {a1, b1, c1, d1}, 0);
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            #1;
            chk($sformatf("d1.abcd%0d", n), {a1, b1, c1, d1}, n);
            chk($sformatf("d1.nodone%0d", n), done1, 0);
        end
        @(posedge clk);
        #1;
        chk("d1.done16", done1, 1);
        chk("d1.abcd_done", {a1, b1, c1, d1}, 0);
        chk("d1.tt", tt1, 16'hF444);
        chk("d1.mcnt", mcnt1, 0);
        chk("d1.pass", pass1, 1);
        @(posedge clk);
        #1;
        chk("d1.done_once", done1, 0);
        chk("d1.busy_idle", busy1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_be_sweep
`default_nettype wire
